uart_rx_manager: RTL and testbench

Sequencer and buffer for the UART receive path. Owns the 8-bit control word driving baud/bit-count/parity/stop/handshake selection, changes it only after the serial line has been quiet for a set period, and pulses the receiver reset on every change. It also captures received bytes into a small FIFO with error tags and drives RTS flow control from FIFO occupancy. It sits between the host/console logic and the UART controller.

---
 rtl/uart_pkg.sv | 35 +++
 rtl/uart_rx_fifo.sv | 81 ++++++++
 rtl/uart_rx_manager.sv | 189 ++++++++++++++++++
 tb/tb_uart_rx_manager.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART receive manager slice:
//   - bit positions of the fields inside the 8-bit UART control word
//   - control word loaded at reset
//   - sequencer state encodings
//   - FIFO entry layout (error tag + received byte)
// ---------------------------------------------------------------------------
package uart_pkg;

    // Control word layout: [7:6] baud, [5] stop, [4] handshake,
    // [3:2] bit count, [1] even, [0] parity enable.
    localparam int CFG_BAUD_HI = 7;
    localparam int CFG_BAUD_LO = 6;
    localparam int CFG_STOP    = 5;
    localparam int CFG_HS      = 4;
    localparam int CFG_BITS_HI = 3;
    localparam int CFG_BITS_LO = 2;
    localparam int CFG_EVEN    = 1;
    localparam int CFG_PAR     = 0;

    // 9600 baud, 8 bits, 1 stop, no parity, no handshake.
    localparam logic [7:0] CFG_RESET_DEFAULT = 8'h4C;

    // Config sequencer states.
    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_PEND  = 2'd1;
    localparam logic [1:0] ST_APPLY = 2'd2;

    typedef struct packed {
        logic       err;
        logic [7:0] data;
    } rx_entry_t;

endpackage

// File: rtl/uart_rx_fifo.sv
// ---------------------------------------------------------------------------
// uart_rx_fifo
// DEPTH x 9-bit show-ahead FIFO holding received bytes with their error tag.
//   clk, rst      : clock, synchronous active-low reset
//   push, wdata   : write request and entry
//   pop           : remove head entry (ignored when empty)
//   flush         : empty the FIFO; beats any same-cycle push/pop
//   rdata         : head entry, all zero when empty
//   empty, full   : status
//   count         : occupancy
//   accepted      : this cycle's push was written
//   dropped       : this cycle's push was lost because the FIFO was full
// ---------------------------------------------------------------------------
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  rx_entry_t                wdata,
    input  logic                     pop,
    input  logic                     flush,
    output rx_entry_t                rdata,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     accepted,
    output logic                     dropped
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    rx_entry_t      mem [DEPTH];
    logic [AW-1:0]  wptr;
    logic [AW-1:0]  rptr;
    logic           do_push;
    logic           do_pop;

    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));

    // A pop on a full FIFO frees the slot the same-cycle push lands in.
    assign do_pop   = pop & ~empty & ~flush;
    assign do_push  = push & ~flush & (~full | do_pop);
    assign accepted = do_push;
    assign dropped  = push & ~flush & full & ~do_pop;

    always_ff @(posedge clk) begin
        if (!rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    // Storage needs no reset: the read side is masked while empty.
    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= wdata;
    end

    always_comb begin
        rdata = '0;
        if (!empty) rdata = mem[rptr];
    end

endmodule

// File: rtl/uart_rx_manager.sv
// ---------------------------------------------------------------------------
// uart_rx_manager
// Receive-path sequencer and buffer between host logic and the UART
// controller. Holds the active control word, applies a new one only after
// the line has idled high for QUIET_CYCLES, pulses the receiver reset on
// each change, buffers received bytes with error tags and drives RTS.
//   clk, rst            : clock, synchronous active-low reset
//   cfg_in, cfg_flush   : new control word / flush-on-apply, taken with cfg_load
//   cfg_load            : 1-cycle config change request
//   cfg_busy            : change pending
//   cfg_out             : active control word
//   rx_rst_n            : receiver reset (low during reset and apply)
//   rx                  : async serial line (quiet detection)
//   rx_data/ready/error : receiver byte handoff (ready/error async)
//   rts                 : flow control, 1 = ready to receive
//   rd_en, rd_data, rd_err : show-ahead read side
//   empty, full, count  : FIFO status
//   overrun, err_count, err_clr : sticky drop flag, error byte count, clear
// ---------------------------------------------------------------------------
module uart_rx_manager
    import uart_pkg::*;
#(
    parameter int         DEPTH        = 8,
    parameter int         QUIET_CYCLES = 5208,
    parameter int         RTS_HIGH     = 6,
    parameter int         RTS_LOW      = 2,
    parameter logic [7:0] RESET_CFG    = CFG_RESET_DEFAULT
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [7:0]              cfg_in,
    input  logic                    cfg_flush,
    input  logic                    cfg_load,
    output logic                    cfg_busy,
    output logic [7:0]              cfg_out,
    output logic                    rx_rst_n,
    input  logic                    rx,
    input  logic [7:0]              rx_data,
    input  logic                    rx_ready,
    input  logic                    rx_error,
    output logic                    rts,
    input  logic                    rd_en,
    output logic [7:0]              rd_data,
    output logic                    rd_err,
    output logic                    empty,
    output logic                    full,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    overrun,
    output logic [7:0]              err_count,
    input  logic                    err_clr
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int QW = (QUIET_CYCLES > 1) ? $clog2(QUIET_CYCLES) : 1;
    localparam logic [QW-1:0] QLAST    = QW'(QUIET_CYCLES - 1);
    localparam logic [CW-1:0] RTS_HI_C = CW'(RTS_HIGH);
    localparam logic [CW-1:0] RTS_LO_C = CW'(RTS_LOW);

    // ---- input synchronizers ----
    logic rx_s1, rx_s2;
    logic rdy_s1, rdy_s2, rdy_s3;
    logic err_s1, err_s2;
    logic push;

    always_ff @(posedge clk) begin
        if (!rst) begin
            rx_s1  <= 1'b0;
            rx_s2  <= 1'b0;
            rdy_s1 <= 1'b0;
            rdy_s2 <= 1'b0;
            rdy_s3 <= 1'b0;
            err_s1 <= 1'b0;
            err_s2 <= 1'b0;
        end else begin
            rx_s1  <= rx;
            rx_s2  <= rx_s1;
            rdy_s1 <= rx_ready;
            rdy_s2 <= rdy_s1;
            rdy_s3 <= rdy_s2;
            err_s1 <= rx_error;
            err_s2 <= err_s1;
        end
    end

    // One push per rising edge of ready; rx_data is held stable by the
    // receiver for as long as ready stays high, so it needs no sync stage.
    assign push = rdy_s2 & ~rdy_s3;

    // ---- config sequencer ----
    logic [1:0]    state;
    logic [7:0]    sh_cfg;
    logic          sh_flush;
    logic [QW-1:0] qcnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= ST_RUN;
            sh_cfg   <= RESET_CFG;
            sh_flush <= 1'b0;
            qcnt     <= '0;
            cfg_out  <= RESET_CFG;
        end else begin
            case (state)
                ST_RUN: begin
                    if (cfg_load) begin
                        sh_cfg   <= cfg_in;
                        sh_flush <= cfg_flush;
                        qcnt     <= '0;
                        state    <= ST_PEND;
                    end
                end
                ST_PEND: begin
                    // A newer request just replaces the shadow; the idle
                    // time already observed still counts.
                    if (cfg_load) begin
                        sh_cfg   <= cfg_in;
                        sh_flush <= cfg_flush;
                    end
                    if (!rx_s2)             qcnt  <= '0;
                    else if (qcnt == QLAST) state <= ST_APPLY;
                    else                    qcnt  <= qcnt + 1'b1;
                end
                ST_APPLY: begin
                    cfg_out <= sh_cfg;
                    state   <= ST_RUN;
                end
                default: state <= ST_RUN;
            endcase
        end
    end

    assign cfg_busy = (state != ST_RUN);
    assign rx_rst_n = rst & (state != ST_APPLY);

    // ---- receive FIFO ----
    rx_entry_t wentry;
    rx_entry_t head;
    logic      fifo_flush;
    logic      accepted;
    logic      dropped;

    assign wentry.err  = err_s2;
    assign wentry.data = rx_data;
    assign fifo_flush  = (state == ST_APPLY) & sh_flush;

    uart_rx_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .wdata    (wentry),
        .pop      (rd_en),
        .flush    (fifo_flush),
        .rdata    (head),
        .empty    (empty),
        .full     (full),
        .count    (count),
        .accepted (accepted),
        .dropped  (dropped)
    );

    assign rd_data = head.data;
    assign rd_err  = head.err;

    // ---- error tracking; clear beats same-cycle events ----
    always_ff @(posedge clk) begin
        if (!rst) begin
            overrun   <= 1'b0;
            err_count <= '0;
        end else if (err_clr) begin
            overrun   <= 1'b0;
            err_count <= '0;
        end else begin
            if (dropped) overrun <= 1'b1;
            if (accepted && wentry.err && err_count != 8'hFF)
                err_count <= err_count + 1'b1;
        end
    end

    // ---- RTS hysteresis, registered off the occupancy ----
    always_ff @(posedge clk) begin
        if (!rst)                      rts <= 1'b1;
        else if (!cfg_out[CFG_HS])     rts <= 1'b1;
        else if (count >= RTS_HI_C)    rts <= 1'b0;
        else if (count <= RTS_LO_C)    rts <= 1'b1;
    end

endmodule

// File: tb/tb_uart_rx_manager.sv
module tb_uart_rx_manager;

    localparam int Q = 5208;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] cfg_in;
    logic       cfg_flush, cfg_load, cfg_busy;
    logic [7:0] cfg_out;
    logic       rx_rst_n, rx;
    logic [7:0] rx_data;
    logic       rx_ready, rx_error, rts, rd_en;
    logic [7:0] rd_data;
    logic       rd_err, empty, full;
    logic [3:0] count;
    logic       overrun;
    logic [7:0] err_count;
    logic       err_clr;

    uart_rx_manager dut (
        .clk(clk), .rst(rst), .cfg_in(cfg_in), .cfg_flush(cfg_flush),
        .cfg_load(cfg_load), .cfg_busy(cfg_busy), .cfg_out(cfg_out),
        .rx_rst_n(rx_rst_n), .rx(rx), .rx_data(rx_data), .rx_ready(rx_ready),
        .rx_error(rx_error), .rts(rts), .rd_en(rd_en), .rd_data(rd_data),
        .rd_err(rd_err), .empty(empty), .full(full), .count(count),
        .overrun(overrun), .err_count(err_count), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    int g_lat  = Q;

    // ---- reference model: queue of {err,data} plus flags ----
    logic [8:0] mq[$];
    logic       m_ovr;
    logic [7:0] m_errc;
    logic       m_rts;
    logic [7:0] m_cfg;

    function automatic void m_rts_upd();
        if (!m_cfg[4])          m_rts = 1'b1;
        else if (mq.size() >= 6) m_rts = 1'b0;
        else if (mq.size() <= 2) m_rts = 1'b1;
    endfunction

    function automatic void m_reset();
        mq.delete();
        m_ovr  = 1'b0;
        m_errc = 8'd0;
        m_rts  = 1'b1;
        m_cfg  = 8'h4C;
    endfunction

    function automatic void m_push(input logic [7:0] d, input logic e);
        if (mq.size() < 8) begin
            mq.push_back({e, d});
            if (e && m_errc != 8'd255) m_errc = m_errc + 8'd1;
        end else begin
            m_ovr = 1'b1;
        end
        m_rts_upd();
    endfunction

    function automatic void m_pop();
        if (mq.size() > 0) void'(mq.pop_front());
        m_rts_upd();
    endfunction

    function automatic logic [32:0] exp_st();
        logic [8:0] hd;
        hd = (mq.size() > 0) ? mq[0] : 9'h0;
        return {4'(mq.size()), mq.size() == 0, mq.size() == 8, hd[7:0], hd[8],
                m_ovr, m_errc, m_rts, m_cfg};
    endfunction

    function automatic logic [32:0] act_st();
        return {count, empty, full, rd_data, rd_err, overrun, err_count, rts, cfg_out};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] d, input logic e);
        rx_data = d; rx_error = e; rx_ready = 1'b1;
        repeat (3) tick();
        rx_ready = 1'b0;
        repeat (2) tick();
        m_push(d, e);
    endtask

    task automatic pop();
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        tick();
        m_pop();
    endtask

    task automatic load_cfg(input logic [7:0] c, input logic f);
        cfg_in = c; cfg_flush = f; cfg_load = 1'b1;
        tick();
        cfg_load = 1'b0;
        n_chk++;
        if (cfg_busy !== 1'b1) begin
            n_fail++; $display("FAIL cfg_busy_set: got %b expected 1", cfg_busy);
        end
    endtask

    task automatic wait_apply(input logic [7:0] c, input logic f, input logic chk);
        int lat = 0;
        while (rx_rst_n !== 1'b0 && lat < Q + 20) begin tick(); lat++; end
        n_chk++;
        if (rx_rst_n !== 1'b0) begin
            n_fail++; $display("FAIL apply_timeout: rx_rst_n %b after %0d cycles, expected 0", rx_rst_n, lat);
        end
        if (chk) begin
            n_chk++;
            if (lat < Q - 2 || lat > Q + 3) begin
                n_fail++; $display("FAIL apply_latency: %0d cycles, expected %0d..%0d", lat, Q - 2, Q + 3);
            end
            g_lat = lat;
        end
        tick();
        m_cfg = c;
        if (f) mq.delete();
        n_chk++;
        if ({rx_rst_n, cfg_busy, cfg_out} !== {1'b1, 1'b0, c}) begin
            n_fail++; $display("FAIL apply_done: rst_n/busy/cfg %b/%b/%h, expected 1/0/%h", rx_rst_n, cfg_busy, cfg_out, c);
        end
        tick();
        m_rts_upd();
        n_chk++;
        if (act_st() !== exp_st()) begin
            n_fail++; $display("FAIL apply_status: got %h expected %h", act_st(), exp_st());
        end
    endtask

    // ---- scenarios ----
    task automatic test_reset();
        rst = 1'b0; cfg_in = 8'h00; cfg_flush = 1'b0; cfg_load = 1'b0; rx = 1'b1;
        rx_data = 8'h00; rx_ready = 1'b0; rx_error = 1'b0; rd_en = 1'b0; err_clr = 1'b0;
        repeat (3) tick();
        m_reset();
        n_chk++;
        if ({rx_rst_n, cfg_busy} !== 2'b00) begin
            n_fail++; $display("FAIL reset_outs: rst_n/busy %b/%b expected 0/0", rx_rst_n, cfg_busy);
        end
        n_chk++;
        if (act_st() !== exp_st()) begin
            n_fail++; $display("FAIL reset_status: got %h expected %h", act_st(), exp_st());
        end
        rst = 1'b1;
        tick();
        n_chk++;
        if ({rx_rst_n, cfg_busy} !== 2'b10) begin
            n_fail++; $display("FAIL reset_release: rst_n/busy %b/%b expected 1/0", rx_rst_n, cfg_busy);
        end
    endtask

    task automatic test_basic();
        rx_data = 8'hA5; rx_error = 1'b0; rx_ready = 1'b1;
        repeat (2) tick();
        n_chk++;
        if (empty !== 1'b1) begin
            n_fail++; $display("FAIL push_early: empty %b one edge before write, expected 1", empty);
        end
        tick();
        m_push(8'hA5, 1'b0);
        n_chk++;
        if (act_st() !== exp_st()) begin
            n_fail++; $display("FAIL push_latency: got %h expected %h", act_st(), exp_st());
        end
        rx_ready = 1'b0;
        repeat (2) tick();
        pop();
        n_chk++;
        if (act_st() !== exp_st()) begin
            n_fail++; $display("FAIL pop_to_empty: got %h expected %h", act_st(), exp_st());
        end
        pop();
        n_chk++;
        if (act_st() !== exp_st()) begin
            n_fail++; $display("FAIL pop_when_empty: got %h expected %h", act_st(), exp_st());
        end
    endtask

    task automatic test_held_level();
        rx_data = 8'h3C; rx_error = 1'b1; rx_ready = 1'b1;
        repeat (12) tick();
        rx_ready = 1'b0;
        repeat (2) tick();
        m_push(8'h3C, 1'b1);
        n_chk++;
        if (act_st() !== exp_st()) begin
            n_fail++; $display("FAIL held_ready_one_push: got %h expected %h", act_st(), exp_st());
        end
        pop();
    endtask

    task automatic test_overrun();
        for (int i = 0; i < 9; i++) begin
            push(8'($urandom), 1'b0);
            if (i == 7) begin
                n_chk++;
                if (act_st() !== exp_st() || full !== 1'b1) begin
                    n_fail++; $display("FAIL fill_8: got %h expected %h", act_st(), exp_st());
                end
            end
        end
        n_chk++;
        if (act_st() !== exp_st()) begin
            n_fail++; $display("FAIL overrun_drop: got %h expected %h", act_st(), exp_st());
        end
        err_clr = 1'b1; tick(); err_clr = 1'b0; tick();
        m_ovr = 1'b0; m_errc = 8'd0;
        n_chk++;
        if (act_st() !== exp_st()) begin
            n_fail++; $display("FAIL err_clr_overrun: got %h expected %h", act_st(), exp_st());
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] d;
        d = 8'($urandom);
        rx_data = d; rx_error = 1'b0; rx_ready = 1'b1;
        repeat (2) tick();
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0; rx_ready = 1'b0;
        m_pop(); m_push(d, 1'b0);
        n_chk++;
        if (act_st() !== exp_st()) begin
            n_fail++; $display("FAIL push_pop_full: got %h expected %h", act_st(), exp_st());
        end
        repeat (2) tick();
        while (mq.size() > 0) begin
            pop();
            n_chk++;
            if (act_st() !== exp_st()) begin
                n_fail++; $display("FAIL drain: got %h expected %h", act_st(), exp_st());
            end
        end
    endtask

    task automatic test_cfg_quiet();
        load_cfg(8'hCC, 1'b0);
        for (int i = 0; i < 6; i++) begin
            rx = 1'b0; tick(); rx = 1'b1;
            repeat (999) tick();
            n_chk++;
            if ({cfg_busy, rx_rst_n, cfg_out} !== {2'b11, 8'h4C}) begin
                n_fail++; $display("FAIL quiet_hold_%0d: busy/rst_n/cfg %b/%b/%h expected 1/1/4c", i, cfg_busy, rx_rst_n, cfg_out);
            end
        end
        wait_apply(8'hCC, 1'b0, 1'b0);
    endtask

    task automatic test_handshake();
        load_cfg(8'hDC, 1'b0);
        wait_apply(8'hDC, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            push(8'($urandom), 1'($urandom));
            n_chk++;
            if (act_st() !== exp_st()) begin
                n_fail++; $display("FAIL hs_push_%0d: got %h expected %h", i, act_st(), exp_st());
            end
        end
        rx_data = 8'h5A; rx_error = 1'b0; rx_ready = 1'b1;
        repeat (3) tick();
        n_chk++;
        if ({count, rts} !== {4'd6, 1'b1}) begin
            n_fail++; $display("FAIL rts_lag: count/rts %0d/%b expected 6/1", count, rts);
        end
        tick();
        n_chk++;
        if (rts !== 1'b0) begin
            n_fail++; $display("FAIL rts_fall: rts %b expected 0", rts);
        end
        rx_ready = 1'b0;
        tick();
        m_push(8'h5A, 1'b0);
        while (mq.size() > 2) begin
            pop();
            n_chk++;
            if (act_st() !== exp_st()) begin
                n_fail++; $display("FAIL hs_pop_%0d: got %h expected %h", mq.size(), act_st(), exp_st());
            end
        end
    endtask

    task automatic test_flush();
        logic [7:0] ec;
        while (mq.size() > 0) pop();
        for (int i = 0; i < 3; i++) push(8'($urandom), 1'($urandom));
        ec = m_errc;
        load_cfg(8'h5D, 1'b1);
        repeat (g_lat - 2) tick();
        rx_data = 8'h77; rx_error = 1'b1; rx_ready = 1'b1;
        repeat (2) tick();
        n_chk++;
        if (rx_rst_n !== 1'b0) begin
            n_fail++; $display("FAIL flush_apply_align: rx_rst_n %b expected 0", rx_rst_n);
        end
        tick();
        rx_ready = 1'b0;
        m_cfg = 8'h5D; mq.delete();
        n_chk++;
        if ({count, empty, err_count, cfg_out} !== {4'd0, 1'b1, ec, 8'h5D}) begin
            n_fail++; $display("FAIL flush_wins: count/empty/errc/cfg %0d/%b/%h/%h expected 0/1/%h/5d", count, empty, err_count, cfg_out, ec);
        end
        repeat (3) tick();
        m_rts_upd();
        n_chk++;
        if (act_st() !== exp_st()) begin
            n_fail++; $display("FAIL flush_status: got %h expected %h", act_st(), exp_st());
        end
    endtask

    task automatic test_err_sat();
        for (int i = 0; i < 256; i++) begin
            push(8'($urandom), 1'b1);
            pop();
        end
        n_chk++;
        if (act_st() !== exp_st() || err_count !== 8'd255) begin
            n_fail++; $display("FAIL err_saturate: got %h expected %h", act_st(), exp_st());
        end
        rx_data = 8'hE1; rx_error = 1'b1; rx_ready = 1'b1;
        repeat (2) tick();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0; rx_ready = 1'b0;
        m_push(8'hE1, 1'b1);
        m_errc = 8'd0; m_ovr = 1'b0;
        repeat (2) tick();
        n_chk++;
        if (act_st() !== exp_st()) begin
            n_fail++; $display("FAIL err_clr_priority: got %h expected %h", act_st(), exp_st());
        end
        pop();
    endtask

    task automatic test_random();
        for (int i = 0; i < 120; i++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r < 6) begin
                push(8'($urandom), 1'($urandom));
            end else if (r < 9) begin
                pop();
            end else begin
                err_clr = 1'b1; tick(); err_clr = 1'b0; tick();
                m_ovr = 1'b0; m_errc = 8'd0;
            end
            n_chk++;
            if (act_st() !== exp_st()) begin
                n_fail++; $display("FAIL random_%0d: got %h expected %h", i, act_st(), exp_st());
            end
        end
    endtask

    task automatic test_reset_pend();
        load_cfg(8'h8D, 1'b0);
        repeat (50) tick();
        rst = 1'b0; tick(); rst = 1'b1;
        m_reset();
        tick();
        n_chk++;
        if (act_st() !== exp_st() || cfg_busy !== 1'b0) begin
            n_fail++; $display("FAIL reset_mid_pend: got %h busy %b expected %h busy 0", act_st(), cfg_busy, exp_st());
        end
        repeat (Q + 20) tick();
        n_chk++;
        if ({cfg_busy, rx_rst_n, cfg_out} !== {2'b01, 8'h4C}) begin
            n_fail++; $display("FAIL shadow_discarded: busy/rst_n/cfg %b/%b/%h expected 0/1/4c", cfg_busy, rx_rst_n, cfg_out);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_held_level();
        test_overrun();
        test_back_to_back();
        test_cfg_quiet();
        test_handshake();
        test_flush();
        test_err_sat();
        test_random();
        test_reset_pend();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached after %0d checks", n_chk);
        $fatal(1, "watchdog");
    end

endmodule
